// File: rtl/router_pkg.sv
// Shared types for the four-port router merge: port count, port index and
// output-stage state, plus the round-robin pick used by the arbiter.
package router_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_e;

  // First requesting port at or above rr, wrapping 3->0.
  function automatic port_idx_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                        input port_idx_t rr);
    port_idx_t idx;
    port_idx_t pick;
    logic      found;
    pick  = rr;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr + port_idx_t'(k);
      if (req[idx] && !found) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/router_merge_if.sv
// Bus between the upstream router outputs / downstream consumer and the merge.
interface router_merge_if
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] din0, din1, din2, din3;
  logic [NUM_PORTS-1:0]  din_en;
  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  ovf;
  logic [DATA_WIDTH-1:0] dout;
  port_idx_t             dout_src;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output din0, din1, din2, din3, din_en, dout_ready,
    input  full, ovf, dout, dout_src, dout_valid
  );

  modport slave (
    input  din0, din1, din2, din3, din_en, dout_ready,
    output full, ovf, dout, dout_src, dout_valid
  );
endinterface

// File: rtl/router_fifo.sv
// Per-port synchronous FIFO; a push while full is legal only alongside a pop,
// since the read data is taken before the slot is overwritten.
module router_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/router_merge.sv
// Merges four unthrottled router outputs into one ready/valid stream through
// per-port FIFOs and a round-robin arbiter feeding a single output register.
module router_merge
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  router_merge_if.slave bus
);
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] din_w, rdata_w;
  logic [NUM_PORTS-1:0] push, pop, full_w, empty_w, drop;
  logic [NUM_PORTS-1:0] ovf_q, ovf_d;

  out_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  port_idx_t             src_q, src_d;
  port_idx_t             rr_q, rr_d;
  port_idx_t             grant;
  logic                  load;

  assign din_w[0] = bus.din0;
  assign din_w[1] = bus.din1;
  assign din_w[2] = bus.din2;
  assign din_w[3] = bus.din3;

  // A full FIFO still accepts when the arbiter pops it in the same cycle.
  assign push = bus.din_en & (~full_w | pop);
  assign drop = bus.din_en & full_w & ~pop;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[i]),
      .wdata_i (din_w[i]),
      .pop_i   (pop[i]),
      .rdata_o (rdata_w[i]),
      .full_o  (full_w[i]),
      .empty_o (empty_w[i])
    );
  end

  // Registered occupancy only, so a word written this cycle waits a cycle.
  assign grant = rr_pick(~empty_w, rr_q);
  assign load  = (|(~empty_w)) && ((state_q == ST_EMPTY) || bus.dout_ready);
  assign pop   = load ? (NUM_PORTS'(1) << grant) : '0;
  assign ovf_d = ovf_q | drop;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (load) begin
      state_d = ST_HOLD;
      dout_d  = rdata_w[grant];
      src_d   = grant;
      rr_d    = grant + 2'd1;
    end else if (state_q == ST_HOLD && bus.dout_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      dout_q  <= '0;
      src_q   <= '0;
      rr_q    <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_src   = src_q;
  assign bus.dout_valid = (state_q == ST_HOLD);
  assign bus.full       = full_w;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_router_merge.sv
// Directed bench for router_merge: expected {src,data} words are queued at
// stimulus time and a negedge monitor pops/compares every accepted output.
module tb_router_merge;
  import router_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  router_merge_if #(.DATA_WIDTH(32)) bus ();

  router_merge #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [1:0]  hold_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [1:0] src, input logic [31:0] data);
    exp_q.push_back({src, data});
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.din_en     = '0;
    bus.dout_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard monitor plus stability check while stalled.
  always @(negedge clk) begin
    logic [33:0] e;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== hold_d || bus.dout_src !== hold_s) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b src=%0d data=%0h expected v=1 src=%0d data=%0h",
                   bus.dout_valid, bus.dout_src, bus.dout, hold_s, hold_d);
        end
      end
      hold_v = 1'b0;
      if (bus.dout_valid && bus.dout_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got src=%0d data=%0h expected none",
                   bus.dout_src, bus.dout);
        end else begin
          e = exp_q.pop_front();
          if ({bus.dout_src, bus.dout} !== e) begin
            errors++;
            $display("FAIL sb_word: got src=%0d data=%0h expected src=%0d data=%0h",
                     bus.dout_src, bus.dout, e[33:32], e[31:0]);
          end
        end
      end else if (bus.dout_valid) begin
        hold_v = 1'b1;
        hold_d = bus.dout;
        hold_s = bus.dout_src;
      end
    end
  end

  initial begin
    int vcnt;
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;
    bus.din_en = '0;
    bus.dout_ready = 1'b0;

    // Reset values, sampled while reset is still high.
    reset = 1'b1;
    step();
    chk("rst_valid", 64'(bus.dout_valid), 0);
    chk("rst_dout",  64'(bus.dout), 0);
    chk("rst_src",   64'(bus.dout_src), 0);
    chk("rst_full",  64'(bus.full), 0);
    chk("rst_ovf",   64'(bus.ovf), 0);
    step();
    reset = 1'b0;

    // Single word: valid two edges after the write cycle, for one cycle.
    expect_word(2'd0, 32'hA5A5A5A5);
    bus.dout_ready = 1'b1;
    bus.din0 = 32'hA5A5A5A5;
    bus.din_en = 4'b0001;
    step();
    bus.din_en = '0;
    chk("single_not_early", 64'(bus.dout_valid), 0);
    step();
    chk("single_valid", 64'(bus.dout_valid), 1);
    chk("single_data",  64'(bus.dout), 64'hA5A5A5A5);
    chk("single_src",   64'(bus.dout_src), 0);
    step();
    chk("single_one_cycle", 64'(bus.dout_valid), 0);

    // All four ports at once drain in port order.
    do_reset();
    bus.dout_ready = 1'b1;
    bus.din0 = 32'h10; bus.din1 = 32'h11; bus.din2 = 32'h12; bus.din3 = 32'h13;
    for (int i = 0; i < 4; i++) expect_word(2'(i), 32'h10 + 32'(i));
    bus.din_en = 4'b1111;
    step();
    bus.din_en = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_src", 64'(bus.dout_src), 64'(i));
    end
    step();
    chk("rr_then_empty", 64'(bus.dout_valid), 0);

    // Overflow: park a port-0 word in the output register first so that
    // port 2's FIFO sees all five writes without being drained.
    do_reset();
    bus.din0 = 32'hEE;
    bus.din_en = 4'b0001;
    expect_word(2'd0, 32'hEE);
    step();
    bus.din_en = '0;
    step();
    for (int n = 1; n <= 5; n++) begin
      bus.din2 = 32'(n);
      bus.din_en = 4'b0100;
      step();
      if (n == 3) chk("ovf_full_at3", 64'(bus.full[2]), 0);
      if (n == 4) begin
        chk("ovf_full_at4", 64'(bus.full[2]), 1);
        chk("ovf_clear_at4", 64'(bus.ovf[2]), 0);
      end
      if (n == 5) begin
        chk("ovf_set_at5", 64'(bus.ovf), 64'b0100);
        chk("ovf_full_at5", 64'(bus.full[2]), 1);
      end
    end
    bus.din_en = '0;
    for (int n = 1; n <= 4; n++) expect_word(2'd2, 32'(n));
    bus.dout_ready = 1'b1;
    repeat (7) step();
    chk("ovf_drained", 64'(bus.dout_valid), 0);
    chk("ovf_sticky", 64'(bus.ovf[2]), 1);
    chk("ovf_full_gone", 64'(bus.full[2]), 0);

    // Ports 0 and 3 fed together under a toggling ready.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      expect_word(2'd0, 32'h100 + 32'(n));
      expect_word(2'd3, 32'h300 + 32'(n));
    end
    for (int c = 0; c < 30; c++) begin
      bus.dout_ready = (c % 2 == 0);
      if (c < 4) begin
        bus.din0 = 32'h100 + 32'(c);
        bus.din3 = 32'h300 + 32'(c);
        bus.din_en = 4'b1001;
      end else begin
        bus.din_en = '0;
      end
      step();
    end
    chk("toggle_drained", 64'(bus.dout_valid), 0);
    chk("toggle_no_ovf", 64'(bus.ovf), 0);
    chk("toggle_sb_empty", 64'(exp_q.size()), 0);

    // Write into a full FIFO in the same cycle it is popped.
    do_reset();
    for (int n = 0; n < 6; n++) expect_word(2'd1, 32'h50 + 32'(n));
    for (int n = 0; n < 5; n++) begin
      bus.din1 = 32'h50 + 32'(n);
      bus.din_en = 4'b0010;
      step();
    end
    chk("popwr_full_before", 64'(bus.full[1]), 1);
    bus.dout_ready = 1'b1;
    bus.din1 = 32'h55;
    step();
    bus.din_en = '0;
    chk("popwr_full_after", 64'(bus.full[1]), 1);
    chk("popwr_no_ovf", 64'(bus.ovf[1]), 0);
    repeat (8) step();
    chk("popwr_drained", 64'(bus.dout_valid), 0);

    // Reset mid-transfer discards everything, din_en ignored during reset.
    do_reset();
    bus.din0 = 32'hD0; bus.din1 = 32'hD1;
    bus.din_en = 4'b0011;
    step();
    bus.din0 = 32'hD2; bus.din1 = 32'hD3;
    step();
    bus.din_en = '0;
    step();
    chk("midrst_pre_valid", 64'(bus.dout_valid), 1);
    reset = 1'b1;
    bus.din_en = 4'b1111;
    step();
    chk("midrst_valid", 64'(bus.dout_valid), 0);
    chk("midrst_dout",  64'(bus.dout), 0);
    chk("midrst_src",   64'(bus.dout_src), 0);
    chk("midrst_full",  64'(bus.full), 0);
    chk("midrst_ovf",   64'(bus.ovf), 0);
    reset = 1'b0;
    bus.din_en = '0;
    bus.dout_ready = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.dout_valid) vcnt++;
    end
    chk("midrst_no_stale", 64'(vcnt), 0);

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
